// File: rtl/miriscv_bus_pkg.sv
// Shared types and default address map for the miriscv data-bus decoder.
package miriscv_bus_pkg;

  localparam int unsigned BUS_AW    = 32;
  localparam int unsigned BUS_DW    = 32;
  localparam int unsigned BUS_BEW   = 4;
  localparam int unsigned DEV_INT_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ERR} bus_state_e;

  typedef struct packed {
    logic               we;
    logic [BUS_BEW-1:0] be;
    logic [BUS_AW-1:0]  addr;
    logic [BUS_DW-1:0]  wdata;
  } bus_req_t;

  localparam logic [BUS_DW-1:0] ERR_RDATA = 32'h0000_0000;

  localparam logic [BUS_AW-1:0] RAM_BASE = 32'h0000_0000;
  localparam logic [BUS_AW-1:0] RAM_MASK = 32'hFFFF_FF80;
  localparam logic [BUS_AW-1:0] KB_BASE  = 32'h0000_0080;
  localparam logic [BUS_AW-1:0] KB_MASK  = 32'hFFFF_FFFC;
  localparam logic [BUS_AW-1:0] FL_BASE  = 32'h0000_00C0;
  localparam logic [BUS_AW-1:0] FL_MASK  = 32'hFFFF_FFC0;

endpackage

// File: rtl/miriscv_bus_addr_match.sv
// Combinational base/mask window matcher; the lowest-index hit wins.
module miriscv_bus_addr_match
  import miriscv_bus_pkg::*;
#(
  parameter int unsigned             N_SLV    = 3,
  parameter int unsigned             SEL_W    = 2,
  parameter logic [N_SLV*BUS_AW-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*BUS_AW-1:0] SLV_MASK = '0
) (
  input  logic [BUS_AW-1:0] addr_i,
  output logic [N_SLV-1:0]  hit_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              any_hit_o
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit_o     = '0;
    sel_o     = '0;
    any_hit_o = 1'b0;
    for (int k = int'(N_SLV) - 1; k >= 0; k--) begin
      if ((addr_i & SLV_MASK[BUS_AW*k +: BUS_AW]) == SLV_BASE[BUS_AW*k +: BUS_AW]) begin
        hit_o     = '0;
        hit_o[k]  = 1'b1;
        sel_o     = SEL_W'(k);
        any_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/miriscv_bus_decoder.sv
// LSU-to-slave data-bus decoder: one outstanding access, error on unmapped address, latched IRQs.
// Optional WAIT timeout is enabled by defining BUS_DECODER_TIMEOUT_EN.
module miriscv_bus_decoder
  import miriscv_bus_pkg::*;
#(
  parameter int unsigned             N_SLV       = 3,
  parameter logic [N_SLV*BUS_AW-1:0] SLV_BASE    = {FL_BASE, KB_BASE, RAM_BASE},
  parameter logic [N_SLV*BUS_AW-1:0] SLV_MASK    = {FL_MASK, KB_MASK, RAM_MASK},
  parameter int unsigned             IRQ_LSB     = 1,
  parameter int unsigned             TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    core_req_i,
  input  logic                    core_we_i,
  input  logic [BUS_BEW-1:0]      core_be_i,
  input  logic [BUS_AW-1:0]       core_addr_i,
  input  logic [BUS_DW-1:0]       core_wdata_i,
  output logic                    core_gnt_o,
  output logic                    core_rvalid_o,
  output logic [BUS_DW-1:0]       core_rdata_o,
  output logic                    core_err_o,
  output logic [N_SLV-1:0]        slv_req_o,
  output logic                    slv_we_o,
  output logic [BUS_BEW-1:0]      slv_be_o,
  output logic [BUS_DW-1:0]       slv_wdata_o,
  output logic [BUS_AW-1:0]       slv_addr_o,
  input  logic [N_SLV-1:0]        slv_rvalid_i,
  input  logic [N_SLV*BUS_DW-1:0] slv_rdata_i,
  input  logic [N_SLV-1:0]        slv_irq_i,
  input  logic [N_SLV-1:0]        irq_clr_i,
  output logic [DEV_INT_W-1:0]    dev_int_o
);

  localparam int unsigned SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  bus_state_e          state_q;
  bus_req_t            req_q;
  logic [SEL_W-1:0]    sel_q;
  logic [N_SLV-1:0]    slv_req_q;
  logic                rvalid_q;
  logic                err_q;
  logic [BUS_DW-1:0]   rdata_q;
  logic [N_SLV-1:0]    pending_q;

  logic [N_SLV-1:0]    hit;
  logic [SEL_W-1:0]    hit_sel;
  logic                any_hit;
  logic [BUS_AW-1:0]   base_sel;
  logic                sel_rvalid;
  logic [BUS_DW-1:0]   sel_rdata;
  logic                to_hit;

  miriscv_bus_addr_match #(
    .N_SLV    (N_SLV),
    .SEL_W    (SEL_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_addr_match (
    .addr_i    (core_addr_i),
    .hit_o     (hit),
    .sel_o     (hit_sel),
    .any_hit_o (any_hit)
  );

  assign base_sel   = SLV_BASE[BUS_AW*hit_sel +: BUS_AW];
  assign sel_rvalid = slv_rvalid_i[sel_q];
  assign sel_rdata  = slv_rdata_i[BUS_DW*sel_q +: BUS_DW];

`ifdef BUS_DECODER_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TO_W-1:0] to_cnt_q;

  // Counts consecutive WAIT cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign to_hit = (state_q == WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign to_hit         = 1'b0;
`endif

  assign core_gnt_o    = core_req_i && (state_q == IDLE);
  assign core_rvalid_o = rvalid_q;
  assign core_err_o    = err_q;
  assign core_rdata_o  = rdata_q;
  assign slv_req_o     = slv_req_q;
  assign slv_we_o      = req_q.we;
  assign slv_be_o      = req_q.be;
  assign slv_wdata_o   = req_q.wdata;
  assign slv_addr_o    = req_q.addr;
  assign dev_int_o     = DEV_INT_W'(pending_q) << IRQ_LSB;

  // Transaction FSM with registered request and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      sel_q     <= '0;
      slv_req_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      slv_req_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (core_req_i) begin
            req_q.we    <= core_we_i;
            req_q.be    <= core_be_i;
            req_q.wdata <= core_wdata_i;
            req_q.addr  <= any_hit ? (core_addr_i - base_sel) : core_addr_i;
            sel_q       <= hit_sel;
            if (any_hit) begin
              slv_req_q <= hit;
              state_q   <= ACCESS;
            end else begin
              state_q   <= ERR;
            end
          end
        end
        ACCESS, WAIT: begin
          if (sel_rvalid) begin
            rvalid_q <= 1'b1;
            rdata_q  <= sel_rdata;
            state_q  <= IDLE;
          end else if (to_hit) begin
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= ERR_RDATA;
            state_q  <= IDLE;
          end else begin
            state_q  <= WAIT;
          end
        end
        ERR: begin
          rvalid_q <= 1'b1;
          err_q    <= 1'b1;
          rdata_q  <= ERR_RDATA;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Interrupt pending bits: a new request beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~irq_clr_i) | slv_irq_i;
    end
  end

endmodule

// File: tb/tb_miriscv_bus_decoder.sv
// Directed self-checking bench for miriscv_bus_decoder (default 3-slave map, TIMEOUT_CYC=4).
module tb_miriscv_bus_decoder;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_gnt;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic [2:0]  slv_req;
  logic        slv_we;
  logic [3:0]  slv_be;
  logic [31:0] slv_wdata;
  logic [31:0] slv_addr;
  logic [2:0]  slv_rvalid;
  logic [95:0] slv_rdata;
  logic [2:0]  slv_irq;
  logic [2:0]  irq_clr;
  logic [31:0] dev_int;

  int total;
  int bad;

  miriscv_bus_decoder #(.TIMEOUT_CYC(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_req_i    (core_req),
    .core_we_i     (core_we),
    .core_be_i     (core_be),
    .core_addr_i   (core_addr),
    .core_wdata_i  (core_wdata),
    .core_gnt_o    (core_gnt),
    .core_rvalid_o (core_rvalid),
    .core_rdata_o  (core_rdata),
    .core_err_o    (core_err),
    .slv_req_o     (slv_req),
    .slv_we_o      (slv_we),
    .slv_be_o      (slv_be),
    .slv_wdata_o   (slv_wdata),
    .slv_addr_o    (slv_addr),
    .slv_rvalid_i  (slv_rvalid),
    .slv_rdata_i   (slv_rdata),
    .slv_irq_i     (slv_irq),
    .irq_clr_i     (irq_clr),
    .dev_int_o     (dev_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    #1;
    total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0h exp=0", core_rvalid); end
    total++; if (slv_req !== 3'b000) begin bad++; $display("FAIL rst_slv_req got=%0h exp=0", slv_req); end
    total++; if (core_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", core_rdata); end
    total++; if (dev_int !== 32'h0) begin bad++; $display("FAIL rst_dev_int got=%0h exp=0", dev_int); end
    total++; if (slv_addr !== 32'h0) begin bad++; $display("FAIL rst_slv_addr got=%0h exp=0", slv_addr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    core_req = 1'b1; core_we = 1'b0; core_be = 4'hF; core_addr = 32'h10;
    #1;
    total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%0h exp=1", core_gnt); end
    step();
    core_req = 1'b0;
    #1;
    total++; if (slv_req !== 3'b001) begin bad++; $display("FAIL rd_slv_req got=%0h exp=1", slv_req); end
    total++; if (slv_addr !== 32'h10) begin bad++; $display("FAIL rd_slv_addr got=%0h exp=10", slv_addr); end
    step();
    #1;
    total++; if (slv_req !== 3'b000) begin bad++; $display("FAIL rd_req_drop got=%0h exp=0", slv_req); end
    total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL rd_early_rvalid got=%0h exp=0", core_rvalid); end
    slv_rvalid = 3'b001;
    step();
    slv_rvalid = 3'b000;
    #1;
    total++; if (core_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid got=%0h exp=1", core_rvalid); end
    total++; if (core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%0h exp=deadbeef", core_rdata); end
    total++; if (core_err !== 1'b0) begin bad++; $display("FAIL rd_err got=%0h exp=0", core_err); end
    step();
    #1;
    total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL rd_pulse got=%0h exp=0", core_rvalid); end
  endtask

  task automatic test_write_slow();
    int pulses;
    pulses = 0;
    core_req = 1'b1; core_we = 1'b1; core_be = 4'b0011; core_addr = 32'hC4; core_wdata = 32'h1234;
    #1;
    total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%0h exp=1", core_gnt); end
    step();
    #1;
    total++; if (slv_req !== 3'b100) begin bad++; $display("FAIL wr_slv_req got=%0h exp=4", slv_req); end
    total++; if (slv_addr !== 32'h04) begin bad++; $display("FAIL wr_slv_addr got=%0h exp=4", slv_addr); end
    total++; if (slv_be !== 4'b0011) begin bad++; $display("FAIL wr_slv_be got=%0h exp=3", slv_be); end
    total++; if (slv_wdata !== 32'h1234 || slv_we !== 1'b1) begin bad++; $display("FAIL wr_fields got=%0h/%0h exp=1234/1", slv_wdata, slv_we); end
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      total++; if (core_gnt !== 1'b0) begin bad++; $display("FAIL wr_no_gnt cyc=%0d got=%0h exp=0", i, core_gnt); end
      if (core_rvalid === 1'b1) pulses++;
      if (i == 4) begin
        slv_rvalid = 3'b100;
        core_req = 1'b0;
      end
    end
    step();
    slv_rvalid = 3'b000;
    #1;
    total++; if (core_rvalid !== 1'b1) begin bad++; $display("FAIL wr_rvalid got=%0h exp=1", core_rvalid); end
    total++; if (core_rdata !== 32'hCAFE0002) begin bad++; $display("FAIL wr_rdata got=%0h exp=cafe0002", core_rdata); end
    if (core_rvalid === 1'b1) pulses++;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      if (core_rvalid === 1'b1) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL wr_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_unmapped_boundary();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h84;
    #1;
    total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL um_gnt got=%0h exp=1", core_gnt); end
    step();
    core_req = 1'b0;
    #1;
    total++; if (slv_req !== 3'b000) begin bad++; $display("FAIL um_slv_req got=%0h exp=0", slv_req); end
    total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL um_early got=%0h exp=0", core_rvalid); end
    step();
    #1;
    total++; if (core_rvalid !== 1'b1 || core_err !== 1'b1) begin bad++; $display("FAIL um_resp got=%0h/%0h exp=1/1", core_rvalid, core_err); end
    total++; if (core_rdata !== 32'h0) begin bad++; $display("FAIL um_rdata got=%0h exp=0", core_rdata); end
    // back-to-back: granted while rvalid is high
    core_req = 1'b1; core_addr = 32'h7F;
    #1;
    total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt got=%0h exp=1", core_gnt); end
    step();
    core_req = 1'b0;
    #1;
    total++; if (slv_req !== 3'b001 || slv_addr !== 32'h7F) begin bad++; $display("FAIL b7f_sel got=%0h/%0h exp=1/7f", slv_req, slv_addr); end
    slv_rvalid = 3'b001;
    step();
    slv_rvalid = 3'b000;
    #1;
    total++; if (core_rvalid !== 1'b1 || core_err !== 1'b0 || core_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL b7f_resp got=%0h/%0h/%0h exp=1/0/deadbeef", core_rvalid, core_err, core_rdata);
    end
    core_req = 1'b1; core_addr = 32'h80;
    #1;
    total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL b80_gnt got=%0h exp=1", core_gnt); end
    step();
    core_req = 1'b0;
    #1;
    total++; if (slv_req !== 3'b010 || slv_addr !== 32'h0) begin bad++; $display("FAIL b80_sel got=%0h/%0h exp=2/0", slv_req, slv_addr); end
    slv_rvalid = 3'b001;
    step();
    #1;
    total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL b80_stray got=%0h exp=0", core_rvalid); end
    slv_rvalid = 3'b010;
    step();
    slv_rvalid = 3'b000;
    #1;
    total++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h11110001) begin bad++; $display("FAIL b80_resp got=%0h/%0h exp=1/11110001", core_rvalid, core_rdata); end
    step();
  endtask

  task automatic test_irq();
    slv_irq = 3'b010;
    step();
    slv_irq = 3'b000;
    #1;
    total++; if (dev_int !== 32'h4) begin bad++; $display("FAIL irq_set got=%0h exp=4", dev_int); end
    step(); step();
    #1;
    total++; if (dev_int !== 32'h4) begin bad++; $display("FAIL irq_hold got=%0h exp=4", dev_int); end
    slv_irq = 3'b010; irq_clr = 3'b010;
    step();
    slv_irq = 3'b000; irq_clr = 3'b000;
    #1;
    total++; if (dev_int !== 32'h4) begin bad++; $display("FAIL irq_setwins got=%0h exp=4", dev_int); end
    irq_clr = 3'b010;
    step();
    irq_clr = 3'b000;
    #1;
    total++; if (dev_int !== 32'h0) begin bad++; $display("FAIL irq_clr got=%0h exp=0", dev_int); end
    slv_irq = 3'b101;
    step();
    slv_irq = 3'b000;
    #1;
    total++; if (dev_int !== 32'hA) begin bad++; $display("FAIL irq_multi got=%0h exp=a", dev_int); end
    rst_n = 1'b0;
    #1;
    total++; if (dev_int !== 32'h0) begin bad++; $display("FAIL irq_rst got=%0h exp=0", dev_int); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    step();
    core_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total++; if (core_rvalid !== 1'b0 || slv_req !== 3'b000) begin bad++; $display("FAIL rm_inrst got=%0h/%0h exp=0/0", core_rvalid, slv_req); end
    step();
    rst_n = 1'b1;
    slv_rvalid = 3'b001;
    step();
    slv_rvalid = 3'b000;
    #1;
    total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL rm_stray got=%0h exp=0", core_rvalid); end
    core_req = 1'b1; core_addr = 32'h20;
    #1;
    total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL rm_gnt got=%0h exp=1", core_gnt); end
    step();
    core_req = 1'b0;
    #1;
    total++; if (slv_req !== 3'b001 || slv_addr !== 32'h20) begin bad++; $display("FAIL rm_sel got=%0h/%0h exp=1/20", slv_req, slv_addr); end
    slv_rvalid = 3'b001;
    step();
    slv_rvalid = 3'b000;
    #1;
    total++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rm_resp got=%0h/%0h exp=1/deadbeef", core_rvalid, core_rdata); end
    step();
  endtask

`ifdef BUS_DECODER_TIMEOUT_EN
  task automatic test_timeout();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    step();
    core_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL to_early cyc=%0d got=%0h exp=0", i, core_rvalid); end
    end
    step();
    #1;
    total++; if (core_rvalid !== 1'b1 || core_err !== 1'b1 || core_rdata !== 32'h0) begin
      bad++; $display("FAIL to_resp got=%0h/%0h/%0h exp=1/1/0", core_rvalid, core_err, core_rdata);
    end
    slv_rvalid = 3'b001;
    step();
    slv_rvalid = 3'b000;
    #1;
    total++; if (core_rvalid !== 1'b0) begin bad++; $display("FAIL to_late got=%0h exp=0", core_rvalid); end
    step();
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_be = 4'h0;
    core_addr = 32'h0; core_wdata = 32'h0;
    slv_rvalid = 3'b000; slv_irq = 3'b000; irq_clr = 3'b000;
    slv_rdata = {32'hCAFE0002, 32'h11110001, 32'hDEADBEEF};
    test_reset();
    test_read();
    test_write_slow();
    test_unmapped_boundary();
    test_irq();
    test_reset_mid();
`ifdef BUS_DECODER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
